// File: rtl/flags_encoder_module.sv
// Two-stage flags encoder with valid/ready handshake on both sides.
// S1 registers the incoming operation; S2 holds the computed N/Z/C/V word.
// A NOP word repeats the flags of the last non-NOP word that reached S2.
// sticky_v and ovf_count track overflow words as they are loaded into S2.
module flags_encoder_module #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       flags,
  input  logic             clear_sticky,
  output logic             sticky_v,
  output logic [7:0]       ovf_count
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_result;
  logic [3:0]       held_flags;
  logic [3:0]       nxt_flags;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             s1_advance;
  logic             in_fire;

  // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
  assign s1_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // Flag computation for the word sitting in S1.
  always_comb begin
    sum       = {1'b0, s1_a} + {1'b0, s1_b};
    diff      = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
    nxt_flags = held_flags;
    case (s1_op)
      OP_ADD: begin
        nxt_flags[3] = sum[WIDTH-1];
        nxt_flags[2] = (sum[WIDTH-1:0] == '0);
        nxt_flags[1] = sum[WIDTH];
        nxt_flags[0] = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                       (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        nxt_flags[3] = diff[WIDTH-1];
        nxt_flags[2] = (diff[WIDTH-1:0] == '0);
        nxt_flags[1] = diff[WIDTH];
        nxt_flags[0] = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                       (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_LOGIC: begin
        nxt_flags[3] = s1_result[WIDTH-1];
        nxt_flags[2] = (s1_result == '0);
        nxt_flags[1] = 1'b0;
        nxt_flags[0] = 1'b0;
      end
      default: nxt_flags = held_flags;
    endcase
  end

  // S1 capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= 2'b00;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_result <= '0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_op     <= op;
      s1_a      <= a;
      s1_b      <= b;
      s1_result <= result;
    end else if (s1_advance) begin
      s1_valid  <= 1'b0;
    end
  end

  // S2 output register plus the flags remembered for NOP words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      flags      <= 4'b0000;
      held_flags <= 4'b0000;
    end else if (s1_advance) begin
      out_valid <= 1'b1;
      flags     <= nxt_flags;
      if (s1_op != 2'b11) begin
        held_flags <= nxt_flags;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Overflow tracking; a clear on the same edge as a V=1 load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v  <= 1'b0;
      ovf_count <= 8'd0;
    end else if (clear_sticky) begin
      sticky_v  <= 1'b0;
      ovf_count <= 8'd0;
    end else if (s1_advance && nxt_flags[0]) begin
      sticky_v <= 1'b1;
      if (ovf_count != 8'hFF) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end
  end

endmodule
